// File: rtl/hermes_pkg.sv
// Shared Hermes NoC types used by the boundary injector.
package hermes_pkg;

    // Boundary port code carried in bits [18:16] of a header flit.
    typedef enum logic [2:0] {
        HERMES_EAST  = 3'd0,
        HERMES_NORTH = 3'd1,
        HERMES_SOUTH = 3'd2,
        HERMES_WEST  = 3'd3,
        HERMES_LOCAL = 3'd4
    } hermes_port_t;

endpackage

// File: rtl/hermes_inject_mux_if.sv
// Bundle of producer streams and the router-side flit port of the injector.
interface hermes_inject_mux_if #(
    parameter int N_CH      = 2,
    parameter int FLIT_SIZE = 32
);
    // Producer side, one lane per channel
    logic [N_CH-1:0]                s_valid_i;
    logic [N_CH-1:0]                s_ready_o;
    logic [N_CH-1:0][FLIT_SIZE-1:0] s_data_i;
    logic [N_CH-1:0]                s_last_i;
    // Router side
    logic                           tx_o;
    logic [FLIT_SIZE-1:0]           data_o;
    logic                           credit_i;
    // Status
    logic [N_CH-1:0]                overflow_o;
    logic                           busy_o;

    // Environment view: drives producer words and router credit.
    modport master (
        output s_valid_i, s_data_i, s_last_i, credit_i,
        input  s_ready_o, tx_o, data_o, overflow_o, busy_o
    );

    // Injector view.
    modport slave (
        input  s_valid_i, s_data_i, s_last_i, credit_i,
        output s_ready_o, tx_o, data_o, overflow_o, busy_o
    );
endinterface

// File: rtl/hermes_inject_mux.sv
// Multi-channel packet injector: buffers one packet per channel and
// serialises complete packets (header, size, payload) onto one Hermes port
// with packet-level round-robin arbitration.
// The header layout places a flag at bit 31, so FLIT_SIZE must be >= 32.
module hermes_inject_mux
    import hermes_pkg::*;
#(
    parameter int                      N_CH        = 2,
    parameter int                      FLIT_SIZE   = 32,
    parameter int                      BUF_DEPTH   = 16,
    parameter logic [N_CH-1:0][15:0]   TARGET_ADDR = {16'h0101, 16'h0000},
    parameter hermes_port_t [N_CH-1:0] TARGET_PORT = '{HERMES_NORTH, HERMES_SOUTH}
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    hermes_inject_mux_if.slave    bus_if
);

    localparam int AW    = $clog2(BUF_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_SIZE,
        ST_PAYLOAD
    } state_t;

    state_t                    state_q, state_d;
    logic [CH_W-1:0]           grant_q, grant_d;
    logic [CH_W-1:0]           rr_q, rr_d;
    logic [CNT_W-1:0]          rcnt_q, rcnt_d;
    logic                      tx_q, tx_d;
    logic [FLIT_SIZE-1:0]      data_q, data_d;

    logic                      drain_done;   // final payload flit transferred this cycle
    logic                      found;
    logic [CH_W-1:0]           pick;

    logic [N_CH-1:0]           accept;
    logic [N_CH-1:0]           full;
    logic [N_CH-1:0]           ovf;
    logic [N_CH-1:0][CNT_W-1:0] wcnt;

    // Packet storage; contents are qualified by wcnt/full, so never reset.
    logic [FLIT_SIZE-1:0]      mem_q [N_CH][BUF_DEPTH];

    // Per-channel fill bookkeeping
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] wcnt_q;
            logic             full_q;
            logic             ovf_q;
            logic             last_slot;

            assign last_slot    = (wcnt_q == CNT_W'(BUF_DEPTH - 1));
            assign accept[gi]   = bus_if.s_valid_i[gi] & ~full_q;
            assign full[gi]     = full_q;
            assign ovf[gi]      = ovf_q;
            assign wcnt[gi]     = wcnt_q;

            // Count accepted words; close the packet on last or when the buffer fills.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    wcnt_q <= '0;
                    full_q <= 1'b0;
                    ovf_q  <= 1'b0;
                end else if (drain_done && (grant_q == CH_W'(gi))) begin
                    wcnt_q <= '0;
                    full_q <= 1'b0;
                end else if (accept[gi]) begin
                    wcnt_q <= wcnt_q + CNT_W'(1);
                    if (bus_if.s_last_i[gi] || last_slot) begin
                        full_q <= 1'b1;
                    end
                    if (!bus_if.s_last_i[gi] && last_slot) begin
                        ovf_q <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Store each accepted word at the channel's current write index.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < N_CH; c++) begin
            if (accept[c]) begin
                mem_q[c][wcnt[c][AW-1:0]] <= bus_if.s_data_i[c];
            end
        end
    end

    // Arbitration scan, next-state and next-flit selection.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        rcnt_d     = rcnt_q;
        tx_d       = tx_q;
        data_d     = data_q;
        drain_done = 1'b0;
        found      = 1'b0;
        pick       = '0;

        // First complete packet at or after rr_q, wrapping around.
        for (int k = 0; k < N_CH; k++) begin
            int idx;
            idx = int'(rr_q) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!found && full[idx]) begin
                found = 1'b1;
                pick  = CH_W'(idx);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d        = pick;
                    tx_d           = 1'b1;
                    data_d         = '0;
                    data_d[31]     = 1'b1;
                    data_d[18:16]  = TARGET_PORT[pick];
                    data_d[15:0]   = TARGET_ADDR[pick];
                    state_d        = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (bus_if.credit_i) begin
                    data_d             = '0;
                    data_d[CNT_W-1:0]  = wcnt[grant_q];
                    state_d            = ST_SIZE;
                end
            end
            ST_SIZE: begin
                if (bus_if.credit_i) begin
                    data_d  = mem_q[grant_q][0];
                    rcnt_d  = CNT_W'(1);
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (bus_if.credit_i) begin
                    if (rcnt_q == wcnt[grant_q]) begin
                        tx_d       = 1'b0;
                        drain_done = 1'b1;
                        rr_d       = (grant_q == CH_W'(N_CH - 1)) ? '0 : grant_q + CH_W'(1);
                        state_d    = ST_IDLE;
                    end else begin
                        data_d = mem_q[grant_q][rcnt_q[AW-1:0]];
                        rcnt_d = rcnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b0;
            end
        endcase
    end

    // Output FSM and flit register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            rcnt_q  <= '0;
            tx_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            rcnt_q  <= rcnt_d;
            tx_q    <= tx_d;
            data_q  <= data_d;
        end
    end

    assign bus_if.s_ready_o  = ~full;
    assign bus_if.tx_o       = tx_q;
    assign bus_if.data_o     = data_q;
    assign bus_if.overflow_o = ovf;
    assign bus_if.busy_o     = (state_q != ST_IDLE);

endmodule
